mem_stage: RTL and testbench

- Pipeline memory stage; consumes the EX-stage output bundle (result, waddr, we, mem_flags, mem_ex_sel, exc_addr_if) and drives the writeback register bundle.
- Loads/stores run on a single-outstanding req/ack data bus; the stage stalls upstream until the access completes.
- Performs byte-lane steering, store replication, load sign/zero extension and misalignment detection.
- Includes an optional bus-timeout watchdog.

---
 rtl/mem_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline memory stage: drives a single-outstanding req/ack data bus for loads/stores,
// steers byte lanes, extends load data and registers the writeback bundle.
module mem_stage #(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  waddr_i,
    input  logic        we_i,
    input  logic [5:0]  mem_flags_i,
    input  logic        mem_ex_sel_i,
    input  logic        exc_addr_if_i,
    output logic        mem_stall_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_sel_o,
    output logic        dmem_we_o,
    output logic        dmem_cyc_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    input  logic        dmem_err_i,
    output logic [31:0] wb_result_o,
    output logic [4:0]  wb_waddr_o,
    output logic        wb_we_o,
    output logic        wb_exc_load_o,
    output logic        wb_exc_store_o,
    output logic [31:0] wb_bad_addr_o,
    output logic        wb_exc_addr_if_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] TMO_LAST = (BUS_TIMEOUT == 0) ? 32'd0 : BUS_TIMEOUT - 1;
    localparam logic        TMO_EN   = (BUS_TIMEOUT != 0);

    state_t      state_q, state_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_sel_q, dmem_sel_d;
    logic        dmem_we_q, dmem_we_d;
    logic        dmem_cyc_q, dmem_cyc_d;
    logic [31:0] wb_result_q, wb_result_d;
    logic [4:0]  wb_waddr_q, wb_waddr_d;
    logic        wb_we_q, wb_we_d;
    logic        wb_exc_load_q, wb_exc_load_d;
    logic        wb_exc_store_q, wb_exc_store_d;
    logic [31:0] wb_bad_addr_q, wb_bad_addr_d;
    logic        wb_exc_addr_if_q, wb_exc_addr_if_d;

    logic        is_rd, is_wr, mem_op, misalign, tmo_hit, reg_we;
    logic [1:0]  size;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        unused_flag;

    // A read flag takes priority when both read and write are set.
    assign is_rd       = mem_flags_i[5];
    assign is_wr       = mem_flags_i[4] & ~mem_flags_i[5];
    assign mem_op      = mem_flags_i[5] | mem_flags_i[4];
    assign size        = mem_flags_i[3:2];
    assign unused_flag = mem_flags_i[0];
    assign reg_we      = we_i & (waddr_i != 5'd0);
    assign tmo_hit     = TMO_EN && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        misalign = 1'b0;
        case (size)
            2'b01:   misalign = result_i[0];
            2'b10:   misalign = (result_i[1:0] != 2'b00);
            2'b11:   misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
    end

    always_comb begin
        lane_sel   = 4'b1111;
        lane_wdata = store_data_i;
        case (size)
            2'b00: begin
                lane_sel   = 4'b0001 << result_i[1:0];
                lane_wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                lane_sel   = result_i[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{store_data_i[15:0]}};
            end
            default: begin
                lane_sel   = 4'b1111;
                lane_wdata = store_data_i;
            end
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata_i[7:0];
        case (result_i[1:0])
            2'b00:   ld_byte = dmem_rdata_i[7:0];
            2'b01:   ld_byte = dmem_rdata_i[15:8];
            2'b10:   ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = result_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (size)
            2'b00:   ld_data = {{24{~mem_flags_i[1] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~mem_flags_i[1] & ld_half[15]}}, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    assign mem_stall_o = ((state_q == S_IDLE) & mem_op & ~misalign) |
                         ((state_q == S_WAIT) & ~dmem_ack_i & ~dmem_err_i & ~tmo_hit);

    always_comb begin
        state_d          = state_q;
        tmo_cnt_d        = tmo_cnt_q;
        dmem_addr_d      = dmem_addr_q;
        dmem_wdata_d     = dmem_wdata_q;
        dmem_sel_d       = dmem_sel_q;
        dmem_we_d        = dmem_we_q;
        dmem_cyc_d       = dmem_cyc_q;
        wb_result_d      = wb_result_q;
        wb_waddr_d       = wb_waddr_q;
        wb_we_d          = wb_we_q;
        wb_exc_load_d    = wb_exc_load_q;
        wb_exc_store_d   = wb_exc_store_q;
        wb_bad_addr_d    = wb_bad_addr_q;
        wb_exc_addr_if_d = wb_exc_addr_if_q;
        case (state_q)
            S_IDLE: begin
                tmo_cnt_d = 32'd0;
                if (mem_op && !misalign) begin
                    dmem_addr_d      = {result_i[31:2], 2'b00};
                    dmem_wdata_d     = lane_wdata;
                    dmem_sel_d       = lane_sel;
                    dmem_we_d        = is_wr;
                    dmem_cyc_d       = 1'b1;
                    state_d          = S_WAIT;
                    wb_result_d      = 32'd0;
                    wb_waddr_d       = 5'd0;
                    wb_we_d          = 1'b0;
                    wb_exc_load_d    = 1'b0;
                    wb_exc_store_d   = 1'b0;
                    wb_bad_addr_d    = 32'd0;
                    wb_exc_addr_if_d = 1'b0;
                end else begin
                    wb_result_d      = result_i;
                    wb_waddr_d       = waddr_i;
                    wb_we_d          = mem_op ? 1'b0 : reg_we;
                    wb_exc_load_d    = mem_op & is_rd;
                    wb_exc_store_d   = mem_op & is_wr;
                    wb_bad_addr_d    = mem_op ? result_i : 32'd0;
                    wb_exc_addr_if_d = exc_addr_if_i;
                end
            end
            S_WAIT: begin
                if (dmem_err_i || tmo_hit || dmem_ack_i) begin
                    state_d          = S_IDLE;
                    tmo_cnt_d        = 32'd0;
                    dmem_cyc_d       = 1'b0;
                    wb_waddr_d       = waddr_i;
                    wb_exc_addr_if_d = exc_addr_if_i;
                    // Error (or watchdog) wins over a simultaneous ack.
                    if (dmem_err_i || tmo_hit) begin
                        wb_result_d    = result_i;
                        wb_we_d        = 1'b0;
                        wb_exc_load_d  = is_rd;
                        wb_exc_store_d = is_wr;
                        wb_bad_addr_d  = result_i;
                    end else begin
                        wb_result_d    = (is_rd && mem_ex_sel_i) ? ld_data : result_i;
                        wb_we_d        = is_rd & reg_we;
                        wb_exc_load_d  = 1'b0;
                        wb_exc_store_d = 1'b0;
                        wb_bad_addr_d  = 32'd0;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            tmo_cnt_q        <= 32'd0;
            dmem_addr_q      <= 32'd0;
            dmem_wdata_q     <= 32'd0;
            dmem_sel_q       <= 4'd0;
            dmem_we_q        <= 1'b0;
            dmem_cyc_q       <= 1'b0;
            wb_result_q      <= 32'd0;
            wb_waddr_q       <= 5'd0;
            wb_we_q          <= 1'b0;
            wb_exc_load_q    <= 1'b0;
            wb_exc_store_q   <= 1'b0;
            wb_bad_addr_q    <= 32'd0;
            wb_exc_addr_if_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            tmo_cnt_q        <= tmo_cnt_d;
            dmem_addr_q      <= dmem_addr_d;
            dmem_wdata_q     <= dmem_wdata_d;
            dmem_sel_q       <= dmem_sel_d;
            dmem_we_q        <= dmem_we_d;
            dmem_cyc_q       <= dmem_cyc_d;
            wb_result_q      <= wb_result_d;
            wb_waddr_q       <= wb_waddr_d;
            wb_we_q          <= wb_we_d;
            wb_exc_load_q    <= wb_exc_load_d;
            wb_exc_store_q   <= wb_exc_store_d;
            wb_bad_addr_q    <= wb_bad_addr_d;
            wb_exc_addr_if_q <= wb_exc_addr_if_d;
        end
    end

    assign dmem_addr_o      = dmem_addr_q;
    assign dmem_wdata_o     = dmem_wdata_q;
    assign dmem_sel_o       = dmem_sel_q;
    assign dmem_we_o        = dmem_we_q;
    assign dmem_cyc_o       = dmem_cyc_q;
    assign wb_result_o      = wb_result_q;
    assign wb_waddr_o       = wb_waddr_q;
    assign wb_we_o          = wb_we_q;
    assign wb_exc_load_o    = wb_exc_load_q;
    assign wb_exc_store_o   = wb_exc_store_q;
    assign wb_bad_addr_o    = wb_bad_addr_q;
    assign wb_exc_addr_if_o = wb_exc_addr_if_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases, randomized loads/stores and
// a writeback scoreboard fed at drive time and drained at each completion.
module tb_mem_stage;

    localparam int unsigned BUS_TMO = 4;
    localparam int W = 73;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] result_i, store_data_i, dmem_rdata_i;
    logic [4:0]  waddr_i;
    logic        we_i, mem_ex_sel_i, exc_addr_if_i, dmem_ack_i, dmem_err_i;
    logic [5:0]  mem_flags_i;
    logic        mem_stall_o, dmem_we_o, dmem_cyc_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, wb_result_o, wb_bad_addr_o;
    logic [3:0]  dmem_sel_o;
    logic [4:0]  wb_waddr_o;
    logic        wb_we_o, wb_exc_load_o, wb_exc_store_o, wb_exc_addr_if_o;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    mem_stage #(.BUS_TIMEOUT(BUS_TMO)) dut (
        .clk(clk), .rst(rst),
        .result_i(result_i), .store_data_i(store_data_i), .waddr_i(waddr_i), .we_i(we_i),
        .mem_flags_i(mem_flags_i), .mem_ex_sel_i(mem_ex_sel_i), .exc_addr_if_i(exc_addr_if_i),
        .mem_stall_o(mem_stall_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_sel_o(dmem_sel_o), .dmem_we_o(dmem_we_o), .dmem_cyc_o(dmem_cyc_o),
        .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i), .dmem_err_i(dmem_err_i),
        .wb_result_o(wb_result_o), .wb_waddr_o(wb_waddr_o), .wb_we_o(wb_we_o),
        .wb_exc_load_o(wb_exc_load_o), .wb_exc_store_o(wb_exc_store_o),
        .wb_bad_addr_o(wb_bad_addr_o), .wb_exc_addr_if_o(wb_exc_addr_if_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_sel(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b00) return 4'(1 << a[1:0]);
        if (sz == 2'b01) return a[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (sz == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                               input logic [31:0] rd, input logic uns);
        logic [31:0] sh;
        sh = rd >> (8 * int'(a[1:0]));
        if (sz == 2'b00) return (uns || !sh[7]) ? {24'h0, sh[7:0]} : {24'hFFFFFF, sh[7:0]};
        if (sz == 2'b01) begin
            sh = a[1] ? {16'h0, rd[31:16]} : {16'h0, rd[15:0]};
            return (uns || !sh[15]) ? sh : {16'hFFFF, sh[15:0]};
        end
        return rd;
    endfunction

    task automatic drive_idle();
        mem_flags_i   = 6'd0;
        we_i          = 1'b0;
        result_i      = 32'd0;
        store_data_i  = 32'd0;
        waddr_i       = 5'd0;
        mem_ex_sel_i  = 1'b0;
        exc_addr_if_i = 1'b0;
        dmem_ack_i    = 1'b0;
        dmem_err_i    = 1'b0;
        dmem_rdata_i  = 32'd0;
    endtask

    // One instruction through the stage; bus response: ack after `delay` wait
    // cycles, optionally err, or nothing at all (watchdog).
    task automatic run_op(input logic [5:0] flags, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] wa, input logic we, input logic ex_sel, input logic exc_if,
                          input int delay, input logic [31:0] rdata,
                          input logic r_ack, input logic r_err, input logic no_resp);
        logic rd, wr, mem, mis;
        logic [1:0] sz;
        logic [31:0] e_res, e_bad;
        logic e_we, e_el, e_es;
        logic [W-1:0] got;
        int n;
        rd  = flags[5];
        wr  = flags[4] & ~flags[5];
        mem = flags[5] | flags[4];
        sz  = flags[3:2];
        mis = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
        e_res = addr; e_bad = 32'd0; e_el = 1'b0; e_es = 1'b0; e_we = 1'b0;
        if (!mem) begin
            e_we = we && (wa != 5'd0);
        end else if (mis || r_err || no_resp) begin
            e_el = rd; e_es = wr; e_bad = addr;
        end else begin
            if (rd && ex_sel) e_res = model_load(sz, addr, rdata, flags[1]);
            e_we = rd && we && (wa != 5'd0);
        end
        exp_q.push_back({e_res, wa, e_we, e_el, e_es, e_bad, exc_if});

        @(posedge clk); #1;
        mem_flags_i = flags; result_i = addr; store_data_i = sdata; waddr_i = wa;
        we_i = we; mem_ex_sel_i = ex_sel; exc_addr_if_i = exc_if;
        #1;
        if (!mem || mis) begin
            check_eq("stall_nowait", 32'(mem_stall_o), 32'd0);
            @(posedge clk); #1;
            check_eq("cyc_nowait", 32'(dmem_cyc_o), 32'd0);
        end else begin
            check_eq("stall_issue", 32'(mem_stall_o), 32'd1);
            @(posedge clk); #1;
            check_eq("cyc_wait", 32'(dmem_cyc_o), 32'd1);
            check_eq("bus_addr", dmem_addr_o, {addr[31:2], 2'b00});
            check_eq("bus_sel", 32'(dmem_sel_o), 32'(model_sel(sz, addr)));
            check_eq("bus_we", 32'(dmem_we_o), 32'(wr));
            check_eq("wb_bubble", 32'(wb_we_o), 32'd0);
            if (wr) check_eq("bus_wdata", dmem_wdata_o, model_wdata(sz, sdata));
            if (no_resp) begin
                n = 0;
                while (dmem_cyc_o && n < 20) begin
                    n++;
                    @(posedge clk); #1;
                end
                check_eq("tmo_cycles", 32'(n), 32'(BUS_TMO));
            end else begin
                for (int i = 0; i < delay; i++) begin
                    check_eq("stall_wait", 32'(mem_stall_o), 32'd1);
                    @(posedge clk); #1;
                    check_eq("cyc_hold", 32'(dmem_cyc_o), 32'd1);
                end
                dmem_ack_i = r_ack; dmem_err_i = r_err; dmem_rdata_i = rdata;
                #1;
                check_eq("stall_done", 32'(mem_stall_o), 32'd0);
                @(posedge clk); #1;
                dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
                check_eq("cyc_done", 32'(dmem_cyc_o), 32'd0);
            end
        end
        drive_idle();
        check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            check_eq("wb_result", wb_result_o, got[72:41]);
            check_eq("wb_waddr", 32'(wb_waddr_o), 32'(got[40:36]));
            check_eq("wb_we", 32'(wb_we_o), 32'(got[35]));
            check_eq("wb_exc_load", 32'(wb_exc_load_o), 32'(got[34]));
            check_eq("wb_exc_store", 32'(wb_exc_store_o), 32'(got[33]));
            check_eq("wb_bad_addr", wb_bad_addr_o, got[32:1]);
            check_eq("wb_exc_if", 32'(wb_exc_addr_if_o), 32'(got[0]));
        end
    endtask

    initial begin
        logic [5:0] fl;
        logic [31:0] ad;
        rst = 1'b1;
        drive_idle();
        #12;
        check_eq("rst_cyc", 32'(dmem_cyc_o), 32'd0);
        check_eq("rst_we", 32'(dmem_we_o), 32'd0);
        check_eq("rst_sel", 32'(dmem_sel_o), 32'd0);
        check_eq("rst_addr", dmem_addr_o, 32'd0);
        check_eq("rst_wdata", dmem_wdata_o, 32'd0);
        check_eq("rst_stall", 32'(mem_stall_o), 32'd0);
        check_eq("rst_wb_result", wb_result_o, 32'd0);
        check_eq("rst_wb_we", 32'(wb_we_o), 32'd0);
        check_eq("rst_wb_exc", 32'({wb_exc_load_o, wb_exc_store_o, wb_exc_addr_if_o}), 32'd0);
        check_eq("rst_wb_bad", wb_bad_addr_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // flags: {read, write, size[1:0], unsigned, reserved}
        run_op(6'b000000, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_op(6'b000000, 32'h1234, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_op(6'b100000, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2, 32'h80FF_0000, 1'b1, 1'b0, 1'b0);
        run_op(6'b100010, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2, 32'h80FF_0000, 1'b1, 1'b0, 1'b0);
        run_op(6'b010100, 32'h202, 32'hDEAD_BEEF, 5'd3, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b0);
        run_op(6'b101000, 32'h6, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 0, 32'h0, 1'b1, 1'b0, 1'b0);
        run_op(6'b011000, 32'h40, 32'h1111_2222, 5'd0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b1);
        run_op(6'b101000, 32'h44, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 0, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0);
        run_op(6'b100100, 32'h82, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1, 32'h8001_7FFF, 1'b1, 1'b0, 1'b0);
        run_op(6'b111000, 32'h90, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 0, 32'h1357_9BDF, 1'b1, 1'b0, 1'b0);
        run_op(6'b011100, 32'h48, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            fl[5]   = 1'($urandom_range(0, 1));
            fl[4]   = fl[5] ? 1'($urandom_range(0, 1)) : 1'b1;
            fl[3:2] = 2'($urandom_range(0, 3));
            fl[1]   = 1'($urandom_range(0, 1));
            fl[0]   = 1'($urandom_range(0, 1));
            ad      = $urandom();
            run_op(fl, ad, $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                   $urandom(), 1'b1, ($urandom_range(0, 7) == 0), 1'b0);
        end

        // reset in the middle of an access, then a stray ack
        @(posedge clk); #1;
        mem_flags_i = 6'b101000; result_i = 32'h100; waddr_i = 5'd6; we_i = 1'b1; mem_ex_sel_i = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_cyc_pre", 32'(dmem_cyc_o), 32'd1);
        drive_idle();
        rst = 1'b1;
        #1;
        check_eq("abort_cyc", 32'(dmem_cyc_o), 32'd0);
        check_eq("abort_stall", 32'(mem_stall_o), 32'd0);
        #1;
        rst = 1'b0;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_ack_i = 1'b0;
        check_eq("late_ack_we", 32'(wb_we_o), 32'd0);
        check_eq("late_ack_cyc", 32'(dmem_cyc_o), 32'd0);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
